// File: rtl/rr_arb_pkg.sv
// Shared types and the round-robin winner search for rr_grant_arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Returns {found, index}: the first set bit scanning upward from ptr+1, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [ID_W-1:0]  ptr);
        logic [ID_W:0]   result;
        logic [ID_W-1:0] cand;
        result = '0;
        // Walk from farthest to nearest so the nearest hit is written last.
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ptr + ID_W'(i);
            if (req[cand]) begin
                result = {1'b1, cand};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/grant_decoder.sv
// Binary holder index plus enable to one-hot grant vector.
module grant_decoder
    import rr_arb_pkg::*;
(
    input  logic [ID_W-1:0]  idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bit
            assign onehot[gi] = en && (idx == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_grant_arbiter.sv
// Four-way round-robin arbiter with sticky grants and registered one-hot output.
// Optional tenure limit enabled by macro ARB_HOLD_LIMIT_EN.
module rr_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             expired
);

    arb_state_t       state_reg, state_next;
    logic [ID_W-1:0]  gnt_id_reg, gnt_id_next;
    logic [ID_W-1:0]  last_reg, last_next;
    logic [N_REQ-1:0] gnt_reg, gnt_dec;
    logic [ID_W:0]    pick_idle, pick_busy;
    logic             new_grant, rotate, hold_hit;

    assign pick_idle = rr_pick(req, last_reg);
    // Excluding the holder lets the same search serve both release and forced rotation.
    assign pick_busy = rr_pick(req & ~gnt_reg, gnt_id_reg);

    always_comb begin
        state_next  = state_reg;
        gnt_id_next = gnt_id_reg;
        last_next   = last_reg;
        new_grant   = 1'b0;
        rotate      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_idle[ID_W]) begin
                    state_next  = BUSY;
                    gnt_id_next = pick_idle[ID_W-1:0];
                    new_grant   = 1'b1;
                end
            end
            BUSY: begin
                if (!req[gnt_id_reg]) begin
                    last_next = gnt_id_reg;
                    if (pick_busy[ID_W]) begin
                        gnt_id_next = pick_busy[ID_W-1:0];
                        new_grant   = 1'b1;
                    end else begin
                        state_next  = IDLE;
                        gnt_id_next = '0;
                    end
                end else if (hold_hit && pick_busy[ID_W]) begin
                    last_next   = gnt_id_reg;
                    gnt_id_next = pick_busy[ID_W-1:0];
                    new_grant   = 1'b1;
                    rotate      = 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                gnt_id_next = '0;
            end
        endcase
    end

    grant_decoder u_grant_decoder (
        .idx    (gnt_id_next),
        .en     (state_next == BUSY),
        .onehot (gnt_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            gnt_id_reg <= '0;
            last_reg   <= ID_W'(N_REQ - 1);
            gnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            gnt_id_reg <= gnt_id_next;
            last_reg   <= last_next;
            gnt_reg    <= gnt_dec;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_reg;
    logic       expired_reg;

    assign hold_hit = (hold_cnt_reg == HOLD_LAST);

    // Counter restarts with every new tenure and saturates when nobody else waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
            expired_reg  <= 1'b0;
        end else begin
            expired_reg <= rotate;
            if (state_next == IDLE || new_grant) begin
                hold_cnt_reg <= '0;
            end else if (!hold_hit) begin
                hold_cnt_reg <= hold_cnt_reg + 8'd1;
            end
        end
    end

    assign expired = expired_reg;
`else
    assign hold_hit = 1'b0;
    assign expired  = 1'b0;
`endif

    assign gnt       = gnt_reg;
    assign gnt_id    = gnt_id_reg;
    assign gnt_valid = (state_reg == BUSY);

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed-vector bench for rr_grant_arbiter; hold-limit expectations follow ARB_HOLD_LIMIT_EN.
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       expired;

    int vec_cnt = 0;
    int err_cnt = 0;

    rr_grant_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic v, input logic ex);
        chk({tag, ".gnt"}, 8'(gnt), 8'(g));
        chk({tag, ".id"}, 8'(gnt_id), 8'(id));
        chk({tag, ".valid"}, 8'(gnt_valid), 8'(v));
        chk({tag, ".exp"}, 8'(expired), 8'(ex));
    endtask

    // Structural invariants checked every cycle away from the active edge.
    always @(negedge clk) begin
        chk("onehot0", 8'($onehot0(gnt)), 8'd1);
        if (gnt_valid) begin
            chk("decode", 8'(gnt), 8'(4'b0001 << gnt_id));
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        tick();
        chk_grant("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_grant("idle_noreq", 4'b0000, 2'd0, 1'b0, 1'b0);

        // First grant one cycle after request
        req = 4'b0001;
        tick();
        chk_grant("first", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Full rotation with each holder briefly releasing
        req = 4'b1111; tick(); chk_grant("rr_hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b1110; tick(); chk_grant("rr_1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1101; tick(); chk_grant("rr_2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b1011; tick(); chk_grant("rr_3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0111; tick(); chk_grant("rr_0", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Walk to holder 2, release to idle, then pointer sits after 2
        req = 4'b0110; tick(); chk_grant("to_1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0100; tick(); chk_grant("to_2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000; tick(); chk_grant("rel_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1001; tick(); chk_grant("ptr_after2", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Asynchronous reset mid-grant of requester 3
        #2 rst_n = 1'b0;
        #1 chk_grant("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        req   = 4'b1000;
        #1 chk("post_rst_wait", 8'(gnt), 8'd0);
        tick();
        chk_grant("post_rst", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Tenure limit: holder 0 with requester 1 waiting
        req = 4'b0000; tick(); chk_grant("idle2", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0001; tick(); chk_grant("hold_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0011;
        tick(); chk_grant("hold_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick(); chk_grant("hold_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick(); chk_grant("hold_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
`ifdef ARB_HOLD_LIMIT_EN
        chk_grant("hold_rot", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick(); chk_grant("hold_after", 4'b0010, 2'd1, 1'b1, 1'b0);
        // Sole requester keeps grant; saturated counter rotates at once when 0 arrives
        req = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick(); chk_grant("sat_keep", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        req = 4'b0011;
        tick(); chk_grant("sat_rot", 4'b0001, 2'd0, 1'b1, 1'b1);
        tick(); chk_grant("sat_after", 4'b0001, 2'd0, 1'b1, 1'b0);
`else
        chk_grant("no_limit", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(); chk_grant("unbounded", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        req = 4'b0010;
        tick(); chk_grant("late_rel", 4'b0010, 2'd1, 1'b1, 1'b0);
`endif
        req = 4'b0000;
        tick(); chk_grant("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
